ysyx_22041211_decode_stage: RTL and testbench
=============================================

// Module: ysyx_22041211_decode_stage
// PURPOSE
//  Registered RV32I/RV32E decode stage between IFU and EXU; replaces the combinational decoder.
//  Accepts {pc,inst} over valid/ready, classifies the opcode into the 3-bit type key and builds the immediate.
//  Extracts rs1/rs2/rd and flags ecall/ebreak/illegal. Halts on ebreak or illegal instruction.
//  One-entry pipeline register; full throughput when downstream is ready.
// PARAMETERS
//  DATA_LEN   32  datapath/imm width; legal values 32, 64 (imm sign-extended to DATA_LEN)
//  ADDR_LEN   32  pc width
//  REG_IDX_W  5   5 = RV32I; 4 = RV32E (any used reg index >= 16 is illegal)
//  CNT_W      32  width of decoded-instruction counter
// PORTS
//  clk        in   1          clock, all state on posedge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          IFU offers inst/in_pc
//  in_ready   out  1          stage can accept
//  inst       in   32         instruction word
//  in_pc      in   ADDR_LEN   pc of inst
//  out_valid  out  1          decoded bundle valid
//  out_ready  in   1          EXU consumes bundle
//  out_pc     out  ADDR_LEN   registered pc
//  key        out  3          000 I, 001 N, 010 U, 011 R, 100 S, 101 J, 110 B, 111 illegal
//  imm        out  DATA_LEN   immediate per key
//  rs1,rs2,rd out  REG_IDX_W  inst[19:15], inst[24:20], inst[11:7] (low REG_IDX_W bits)
//  is_ecall   out  1          inst == 32'h0000_0073
//  is_ebreak  out  1          inst == 32'h0010_0073
//  illegal    out  1          key==111 or RV32E index violation
//  halt       out  1          stage in HALT state
//  halt_code  out  1          0 = ebreak, 1 = illegal
//  dec_cnt    out  CNT_W      count of accepted instructions, wraps
// BEHAVIOUR
//  Reset: all outputs 0, state RUN, in_ready then = 1.
//  Opcode map: I = 0010011/0000011/1100111; N = 1110011 (only exact ecall/ebreak, else 111);
//   U = 0110111/0010111; R = 0110011; S = 0100011; J = 1101111; B = 1100011; all else 111.
//  imm: I {sx,inst[31:20]}; S {sx,inst[31:25],inst[11:7]}; B {sx,inst[31],inst[7],inst[30:25],inst[11:8],0};
//   U {sx,inst[31:12],12'b0}; J {sx,inst[31],inst[19:12],inst[20],inst[30:21],0}; N/R/111 -> 0.
//   sx = replicated inst[31] to DATA_LEN.
//  RV32E check (REG_IDX_W==4): rd used by I/U/R/J, rs1 by I/R/S/B, rs2 by R/S/B; bit4 set -> illegal=1.
//  Handshake: in_ready = (state==RUN) && (!out_valid || out_ready).
//   Accept (in_valid&&in_ready): outputs registered next edge, out_valid=1, dec_cnt+1.
//   out_valid&&out_ready with no accept -> out_valid=0. Both same cycle -> new bundle replaces, out_valid stays 1.
//   out_valid=1 && !out_ready: all outputs held stable; inst/in_pc ignored.
//  FSM: RUN -> HALT on accepting ebreak (halt_code=0) or illegal (halt_code=1); halt=1 same edge as out_valid.
//   The halting bundle is still delivered. HALT: in_ready=0, leaves only by rst.
//   ecall does not halt.
//  dec_cnt wraps from all-ones to 0.
//  rst mid-transfer: bundle dropped, out_valid=0, state RUN, count 0, next edge.
//  Latency: 1 cycle from accept to out_valid.
// TESTING
//  addi x1,x0,-1 (32'hFFF0_0093), out_ready=1 -> next cycle key=000, imm=FFFF_FFFF, rd=1, dec_cnt=1.
//  sw x2,-4(x1) 32'hFE20_AE23 -> key=100, imm=FFFF_FFFC, rs1=1, rs2=2; beq 32'hFE00_0EE3 -> key=110, imm=FFFF_FFFC.
//  Back-to-back 4 insts, out_ready low cycles 2-3 -> bundle 2 held, in_ready=0, no loss or duplication, dec_cnt=4.
//  ebreak 32'h0010_0073 -> is_ebreak=1, halt=1, halt_code=0, in_ready=0 thereafter; lui next ignored.
//  32'h0000_0000 -> key=111, illegal=1, halt_code=1; rst pulse -> halt=0, in_ready=1, dec_cnt=0.
//  REG_IDX_W=4: add x16,x1,x2 (32'h0020_8833) -> illegal=1, halt=1.

Source files
------------

// File: rtl/ysyx_22041211_decode_stage.sv
// Registered RV32I/RV32E decoder between IFU and EXU; accept-to-out_valid latency is 1 cycle.
// One-entry register: holds the bundle while !out_ready, refills in the same cycle it drains; HALT blocks input until rst.
module ysyx_22041211_decode_stage #(
  parameter int DATA_LEN  = 32,
  parameter int ADDR_LEN  = 32,
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          inst,
  input  logic [ADDR_LEN-1:0]  in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_LEN-1:0]  out_pc,
  output logic [2:0]           key,
  output logic [DATA_LEN-1:0]  imm,
  output logic [REG_IDX_W-1:0] rs1,
  output logic [REG_IDX_W-1:0] rs2,
  output logic [REG_IDX_W-1:0] rd,
  output logic                 is_ecall,
  output logic                 is_ebreak,
  output logic                 illegal,
  output logic                 halt,
  output logic                 halt_code,
  output logic [CNT_W-1:0]     dec_cnt
);

  localparam logic [2:0] K_I = 3'b000;
  localparam logic [2:0] K_N = 3'b001;
  localparam logic [2:0] K_U = 3'b010;
  localparam logic [2:0] K_R = 3'b011;
  localparam logic [2:0] K_S = 3'b100;
  localparam logic [2:0] K_J = 3'b101;
  localparam logic [2:0] K_B = 3'b110;
  localparam logic [2:0] K_X = 3'b111;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [ADDR_LEN-1:0]  pc;
    logic [2:0]           key;
    logic [DATA_LEN-1:0]  imm;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 is_ecall;
    logic                 is_ebreak;
    logic                 illegal;
  } bundle_t;

  state_t            state, state_next;
  bundle_t           dec_d, dec_q;
  logic              vld_q;
  logic              halt_code_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              halt_req;
  logic [2:0]        key_d;
  logic signed [31:0] imm32;
  logic              rd_used, rs1_used, rs2_used, e_bad;

  always_comb begin
    key_d = K_X;
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: key_d = K_I;
      7'b1110011: key_d = (inst == 32'h0000_0073 || inst == 32'h0010_0073) ? K_N : K_X;
      7'b0110111, 7'b0010111:             key_d = K_U;
      7'b0110011:                         key_d = K_R;
      7'b0100011:                         key_d = K_S;
      7'b1101111:                         key_d = K_J;
      7'b1100011:                         key_d = K_B;
      default:                            key_d = K_X;
    endcase

    // Every format fits in 32 bits; widening the signed value gives the DATA_LEN sign extension.
    imm32 = '0;
    case (key_d)
      K_I:     imm32 = $signed({{20{inst[31]}}, inst[31:20]});
      K_S:     imm32 = $signed({{20{inst[31]}}, inst[31:25], inst[11:7]});
      K_B:     imm32 = $signed({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
      K_U:     imm32 = $signed({inst[31:12], 12'b0});
      K_J:     imm32 = $signed({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      default: imm32 = '0;
    endcase

    rd_used  = (key_d == K_I) || (key_d == K_U) || (key_d == K_R) || (key_d == K_J);
    rs1_used = (key_d == K_I) || (key_d == K_R) || (key_d == K_S) || (key_d == K_B);
    rs2_used = (key_d == K_R) || (key_d == K_S) || (key_d == K_B);
    e_bad    = (REG_IDX_W == 4) &&
               ((rd_used && inst[11]) || (rs1_used && inst[19]) || (rs2_used && inst[24]));

    dec_d           = '0;
    dec_d.pc        = in_pc;
    dec_d.key       = key_d;
    dec_d.imm       = DATA_LEN'(imm32);
    dec_d.rs1       = inst[15 +: REG_IDX_W];
    dec_d.rs2       = inst[20 +: REG_IDX_W];
    dec_d.rd        = inst[7 +: REG_IDX_W];
    dec_d.is_ecall  = (inst == 32'h0000_0073);
    dec_d.is_ebreak = (inst == 32'h0010_0073);
    dec_d.illegal   = (key_d == K_X) || e_bad;
  end

  assign in_ready = (state == RUN) && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign halt_req = accept && (dec_d.is_ebreak || dec_d.illegal);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == RUN && halt_req) state_next = HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q       <= '0;
      vld_q       <= 1'b0;
      cnt_q       <= '0;
      halt_code_q <= 1'b0;
    end else begin
      if (accept) begin
        dec_q <= dec_d;
        vld_q <= 1'b1;
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (out_ready) begin
        vld_q <= 1'b0;
      end
      if (halt_req) halt_code_q <= dec_d.illegal;
    end
  end

  assign out_valid = vld_q;
  assign out_pc    = dec_q.pc;
  assign key       = dec_q.key;
  assign imm       = dec_q.imm;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign rd        = dec_q.rd;
  assign is_ecall  = dec_q.is_ecall;
  assign is_ebreak = dec_q.is_ebreak;
  assign illegal   = dec_q.illegal;
  assign halt      = (state == HALT);
  assign halt_code = halt_code_q;
  assign dec_cnt   = cnt_q;

endmodule

// File: tb/tb_ysyx_22041211_decode_stage.sv
// Directed bench: RV32I/32-bit instance for decode, backpressure and halt; RV32E/64-bit/3-bit-counter instance for index check, sign extension and wrap.
module tb_ysyx_22041211_decode_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // RV32I instance
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst, in_pc, out_pc, imm, dec_cnt;
  logic [2:0]  key;
  logic [4:0]  rs1, rs2, rd;
  logic        is_ecall, is_ebreak, illegal, halt, halt_code;

  // RV32E instance
  logic        e_rst, e_in_valid, e_in_ready, e_out_valid, e_out_ready;
  logic [31:0] e_inst, e_in_pc, e_out_pc;
  logic [63:0] e_imm;
  logic [2:0]  e_key, e_dec_cnt;
  logic [3:0]  e_rs1, e_rs2, e_rd;
  logic        e_is_ecall, e_is_ebreak, e_illegal, e_halt, e_halt_code;

  int n_chk  = 0;
  int n_pass = 0;

  ysyx_22041211_decode_stage #(
    .DATA_LEN(32), .ADDR_LEN(32), .REG_IDX_W(5), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .key(key), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .is_ecall(is_ecall),
    .is_ebreak(is_ebreak), .illegal(illegal), .halt(halt), .halt_code(halt_code),
    .dec_cnt(dec_cnt)
  );

  ysyx_22041211_decode_stage #(
    .DATA_LEN(64), .ADDR_LEN(32), .REG_IDX_W(4), .CNT_W(3)
  ) dut_e (
    .clk(clk), .rst(e_rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .inst(e_inst),
    .in_pc(e_in_pc), .out_valid(e_out_valid), .out_ready(e_out_ready), .out_pc(e_out_pc),
    .key(e_key), .imm(e_imm), .rs1(e_rs1), .rs2(e_rs2), .rd(e_rd), .is_ecall(e_is_ecall),
    .is_ebreak(e_is_ebreak), .illegal(e_illegal), .halt(e_halt), .halt_code(e_halt_code),
    .dec_cnt(e_dec_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] i, input logic [31:0] pc);
    in_valid = 1'b1;
    inst     = i;
    in_pc    = pc;
    tick();
  endtask

  task automatic e_put(input logic [31:0] i, input logic [31:0] pc);
    e_in_valid = 1'b1;
    e_inst     = i;
    e_in_pc    = pc;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; inst = '0; in_pc = '0;
    e_rst = 1'b1; e_in_valid = 1'b0; e_out_ready = 1'b1; e_inst = '0; e_in_pc = '0;
    tick(); tick();
    rst = 1'b0; e_rst = 1'b0;
    #1;
    check("rst_vld", out_valid, 0);
    check("rst_halt", halt, 0);
    check("rst_cnt", dec_cnt, 0);
    check("rst_rdy", in_ready, 1);
    check("rst_key", key, 0);
    check("rst_imm", imm, 0);

    put(32'hFFF0_0093, 32'h100);
    check("addi_vld", out_valid, 1);
    check("addi_key", key, 3'b000);
    check("addi_imm", imm, 32'hFFFF_FFFF);
    check("addi_rd", rd, 1);
    check("addi_cnt", dec_cnt, 1);
    check("addi_pc", out_pc, 32'h100);
    check("addi_ill", illegal, 0);

    put(32'hFE20_AE23, 32'h104);
    check("sw_key", key, 3'b100);
    check("sw_imm", imm, 32'hFFFF_FFFC);
    check("sw_rs1", rs1, 1);
    check("sw_rs2", rs2, 2);
    check("sw_cnt", dec_cnt, 2);

    put(32'hFE00_0EE3, 32'h108);
    check("beq_key", key, 3'b110);
    check("beq_imm", imm, 32'hFFFF_FFFC);

    put(32'h1234_52B7, 32'h10C);
    check("lui_key", key, 3'b010);
    check("lui_imm", imm, 32'h1234_5000);
    check("lui_rd", rd, 5);

    put(32'hFFFF_F0B7, 32'h110);
    check("luin_imm", imm, 32'hFFFF_F000);

    put(32'h0080_00EF, 32'h114);
    check("jal_key", key, 3'b101);
    check("jal_imm", imm, 32'h8);
    check("jal_rd", rd, 1);

    put(32'h0020_81B3, 32'h118);
    check("add_key", key, 3'b011);
    check("add_imm", imm, 0);
    check("add_rd", rd, 3);

    put(32'h0000_0073, 32'h11C);
    check("ecall_key", key, 3'b001);
    check("ecall_flag", is_ecall, 1);
    check("ecall_nohalt", halt, 0);
    check("ecall_cnt", dec_cnt, 8);

    in_valid = 1'b0;
    tick();
    check("drain_vld", out_valid, 0);
    check("drain_cnt", dec_cnt, 8);

    // back-to-back with a two-cycle stall on the second bundle
    put(32'h0010_0093, 32'h200);
    check("bp_a_pc", out_pc, 32'h200);
    put(32'h0020_0113, 32'h204);
    check("bp_b_pc", out_pc, 32'h204);
    out_ready = 1'b0;
    inst = 32'h0030_0193; in_pc = 32'h208;
    #1;
    check("bp_stall_rdy", in_ready, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("bp_hold_vld", out_valid, 1);
      check("bp_hold_pc", out_pc, 32'h204);
      check("bp_hold_imm", imm, 2);
      check("bp_hold_cnt", dec_cnt, 10);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_rdy", in_ready, 1);
    tick();
    check("bp_c_pc", out_pc, 32'h208);
    check("bp_c_rd", rd, 3);
    put(32'h0040_0213, 32'h20C);
    check("bp_d_pc", out_pc, 32'h20C);
    check("bp_d_rd", rd, 4);
    in_valid = 1'b0;
    tick();
    check("bp_end_vld", out_valid, 0);
    check("bp_end_cnt", dec_cnt, 12);

    put(32'h0010_0073, 32'h300);
    check("ebrk_flag", is_ebreak, 1);
    check("ebrk_key", key, 3'b001);
    check("ebrk_vld", out_valid, 1);
    check("ebrk_halt", halt, 1);
    check("ebrk_code", halt_code, 0);
    check("ebrk_rdy", in_ready, 0);
    put(32'h1234_52B7, 32'h304);
    check("halted_vld", out_valid, 0);
    check("halted_cnt", dec_cnt, 13);
    check("halted_pc", out_pc, 32'h300);
    check("halted_rdy", in_ready, 0);

    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst2_halt", halt, 0);
    check("rst2_rdy", in_ready, 1);
    check("rst2_cnt", dec_cnt, 0);

    put(32'h0000_0000, 32'h400);
    check("ill_key", key, 3'b111);
    check("ill_flag", illegal, 1);
    check("ill_halt", halt, 1);
    check("ill_code", halt_code, 1);
    check("ill_imm", imm, 0);
    check("ill_cnt", dec_cnt, 1);

    // reset while a bundle is stalled downstream
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst3_vld", out_valid, 0);
    check("rst3_halt", halt, 0);
    check("rst3_code", halt_code, 0);
    check("rst3_cnt", dec_cnt, 0);

    // RV32E, 64-bit data, 3-bit counter
    for (int k = 0; k < 8; k++) begin
      e_put(32'h0020_81B3, 32'h500 + 32'(4 * k));
      check("e_add_ill", e_illegal, 0);
      if (k == 6) check("e_cnt7", e_dec_cnt, 7);
    end
    check("e_cnt_wrap", e_dec_cnt, 0);
    check("e_add_rd", e_rd, 3);
    e_put(32'hFFF0_0093, 32'h600);
    check("e_imm64", e_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("e_cnt1", e_dec_cnt, 1);
    e_put(32'h0020_8833, 32'h604);
    check("e_x16_ill", e_illegal, 1);
    check("e_x16_key", e_key, 3'b011);
    check("e_x16_rd", e_rd, 0);
    check("e_x16_halt", e_halt, 1);
    check("e_x16_code", e_halt_code, 1);
    check("e_x16_rdy", e_in_ready, 0);
    e_in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
